// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt;
    logic [2*WIDTH-1:0]     acc, acc_next, prod;
    logic [WIDTH-1:0]       opnd, a_orig, quot, rem, mag_a, mag_b;
    logic [WIDTH:0]         mul_sum, div_shift, div_diff;
    logic                   is_mul, neg_res, neg_rem, div_zero;
    logic                   signed_op, accept, last;
    logic signed [WIDTH-1:0] a_s, b_s;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign a_s       = a;
    assign b_s       = b;
    assign signed_op = (op == 3'd0) || (op == 3'd2);
    assign mag_a     = cond_neg_w(a, signed_op && (a_s < 0));
    assign mag_b     = cond_neg_w(b, signed_op && (b_s < 0));
    assign accept    = (state == IDLE) && start && !op[2];
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == RUN) && last;
            if (state == IDLE) cnt <= '0;
            else               cnt <= cnt + 1'b1;
        end
    end

    // One iteration: multiply adds into the upper half then shifts right;
    // divide shifts the remainder left and keeps the difference if no borrow.
    always_comb begin
        acc_next  = acc;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_mul)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign prod = cond_neg_2w(acc_next, neg_res);
    assign quot = cond_neg_w(acc_next[WIDTH-1:0], neg_res);
    assign rem  = cond_neg_w(acc_next[2*WIDTH-1:WIDTH], neg_rem);

    // Operand capture at start; magnitudes only, signs kept for the final write.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_mul   <= !op[1];
            neg_res  <= signed_op && ((a_s < 0) != (b_s < 0));
            neg_rem  <= signed_op && (a_s < 0);
            div_zero <= op[1] && (b == '0);
            a_orig   <= a;
            if (!op[1]) begin
                opnd <= mag_a;
                acc  <= {{WIDTH{1'b0}}, mag_b};
            end else begin
                opnd <= mag_b;
                acc  <= {{WIDTH{1'b0}}, mag_a};
            end
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    // Architectural HI/LO: written on the final iteration or by MTHI/MTLO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == RUN && last) begin
            if (is_mul) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end else if (div_zero) begin
                hi <= a_orig;
                lo <= '1;
            end else begin
                hi <= rem;
                lo <= quot;
            end
        end else if (state == IDLE && start && op == 3'd4) begin
            hi <= a;
        end else if (state == IDLE && start && op == 3'd5) begin
            lo <= a;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference model feeds a scoreboard queue
// at issue time; each scenario task pops and compares when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      p;
        logic [63:0] u;
        int          q, r;
        e.hi = '0;
        e.lo = '0;
        case (o)
            3'd0: begin
                p = longint'($signed(x)) * longint'($signed(y));
                {e.hi, e.lo} = p;
            end
            3'd1: begin
                u = {32'b0, x} * {32'b0, y};
                {e.hi, e.lo} = u;
            end
            3'd2: begin
                if (y == 0) begin
                    e.lo = '1; e.hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = '0;
                end else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    e.lo = q; e.hi = r;
                end
            end
            3'd3: begin
                if (y == 0) begin
                    e.lo = '1; e.hi = x;
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        if (!o[2]) sb.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op = 3'd6; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h want=0", hi); end
        checks++; if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h want=0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd4, 32'h1234_5678, 32'h0);
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi got=%h want=12345678", hi); end
        checks++; if (lo !== 32'h0)         begin failures++; $display("FAIL mthi_lo got=%h want=0", lo); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL mthi_busy got=%b want=0", busy); end
        issue(3'd5, 32'h9ABC_DEF0, 32'h0);
        checks++; if (lo !== 32'h9ABC_DEF0) begin failures++; $display("FAIL mtlo_lo got=%h want=9abcdef0", lo); end
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi got=%h want=12345678", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mtlo_ctrl got=%b%b want=00", busy, done); end
        issue(3'd7, 32'hFFFF_FFFF, 32'h1);
        checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0)
            begin failures++; $display("FAIL noop got=%h_%h want=12345678_9abcdef0", hi, lo); end
    endtask

    task automatic run_vector(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string name);
        int   lat;
        exp_t e;
        logic [31:0] hi_before, lo_before;
        hi_before = hi; lo_before = lo;
        issue(o, x, y);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy got=%b want=1", name, busy); end
        repeat (5) @(posedge clk); #1;
        checks++; if (hi !== hi_before || lo !== lo_before)
            begin failures++; $display("FAIL %s_hold got=%h_%h want=%h_%h", name, hi, lo, hi_before, lo_before); end
        wait_done(lat);
        lat = (lat < 0) ? lat : lat + 5;
        checks++; if (lat !== 32) begin failures++; $display("FAIL %s_latency got=%0d want=32", name, lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 32'hx};
        checks++; if (hi !== e.hi) begin failures++; $display("FAIL %s_hi got=%h want=%h", name, hi, e.hi); end
        checks++; if (lo !== e.lo) begin failures++; $display("FAIL %s_lo got=%h want=%h", name, lo, e.lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL %s_pulse got=%b%b want=00", name, done, busy); end
    endtask

    task automatic test_multiply();
        run_vector(3'd0, 32'hFFFF_FFFD, 32'h7, "mult_neg");
        run_vector(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_vector(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
    endtask

    task automatic test_divide();
        run_vector(3'd2, 32'hFFFF_FFF9, 32'h2, "div_neg");
        run_vector(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_vector(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, "div_negdivisor");
        run_vector(3'd3, 32'hFFFF_FFFF, 32'h0000_0010, "divu_big");
    endtask

    task automatic test_div_zero();
        run_vector(3'd3, 32'd100, 32'h0, "divu_zero");
        run_vector(3'd2, 32'hFFFF_FF00, 32'h0, "div_zero_signed");
    endtask

    task automatic test_busy_ignore();
        int   lat;
        exp_t e;
        issue(3'd1, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1 op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        checks++; if (lo === 32'hDEAD_BEEF) begin failures++; $display("FAIL busy_mtlo got=%h want=not deadbeef", lo); end
        wait_done(lat);
        lat = (lat < 0) ? lat : lat + 10;
        checks++; if (lat !== 32) begin failures++; $display("FAIL busy_latency got=%0d want=32", lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 32'hx};
        checks++; if (lo !== e.lo) begin failures++; $display("FAIL busy_lo got=%h want=%h", lo, e.lo); end
        checks++; if (hi !== e.hi) begin failures++; $display("FAIL busy_hi got=%h want=%h", hi, e.hi); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int   lat;
        exp_t e;
        issue(3'd3, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL rstmid_hilo got=%h_%h want=0_0", hi, lo); end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        issue(3'd0, 32'd2, 32'd3);
        wait_done(lat);
        checks++; if (lat !== 32) begin failures++; $display("FAIL rstmid_latency got=%0d want=32", lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 32'hx};
        checks++; if (lo !== e.lo || hi !== e.hi) begin failures++; $display("FAIL rstmid_result got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        logic [2:0] ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd0, 3'd3, 3'd1};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], $urandom, (i % 3 == 2) ? $urandom_range(1, 255) : $urandom);
            wait_done(lat);
            checks++; if (lat !== 32) begin failures++; $display("FAIL b2b%0d_latency got=%0d want=32", i, lat); end
            e = (sb.size() > 0) ? sb.pop_front() : '{32'hx, 32'hx};
            checks++; if (hi !== e.hi || lo !== e.lo)
                begin failures++; $display("FAIL b2b%0d_result op=%0d got=%h_%h want=%h_%h", i, ops[i], hi, lo, e.hi, e.lo); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_multiply();
        test_divide();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
